// File: rtl/cpu_mem_arbiter.sv
// Shares one SRAM-like bus between the I-fetch and D-access ports.
// D wins by fixed priority; a starvation guard forces I after STARVE_LIMIT D grants.
module cpu_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_addr_ok,
   output logic              i_data_ok,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [3:0]        d_sel,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_addr_ok,
   output logic              d_data_ok,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_req,
   output logic              m_wr,
   output logic [3:0]        m_sel,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              owner
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          grant_d, grant_i;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      i_data_ok  = 1'b0;
      d_data_ok  = 1'b0;
      unique case (state)
         IDLE: begin
            // gate grants while rst is held so no addr_ok leaks out of reset
            if (!rst) begin
               grant_d = d_req && !(i_req && cnt == LIM);
               grant_i = i_req && !grant_d;
            end
            if (grant_d) begin
               state_next = ADDR;
               if (!i_req)
                  cnt_next = '0;
               else if (cnt != LIM)
                  cnt_next = cnt + CW'(1);
            end else if (grant_i) begin
               state_next = ADDR;
               cnt_next   = '0;
            end
         end
         ADDR: begin
            if (m_addr_ok)
               state_next = DATA;
         end
         DATA: begin
            if (m_data_ok) begin
               i_data_ok  = !owner;
               d_data_ok  = owner;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         owner   <= 1'b0;
         m_wr    <= 1'b0;
         m_sel   <= 4'h0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (grant_d) begin
            owner   <= 1'b1;
            m_wr    <= d_wr;
            m_sel   <= d_sel;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
         end else if (grant_i) begin
            owner   <= 1'b0;
            m_wr    <= 1'b0;
            m_sel   <= 4'hF;
            m_addr  <= i_addr;
            m_wdata <= '0;
         end
      end
   end

   assign m_req     = (state == ADDR);
   assign i_addr_ok = grant_i;
   assign d_addr_ok = grant_d;
   assign i_rdata   = m_rdata;
   assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: per-cycle vector table
// plus hand sequences for starvation, slow write, async reset.
module tb_cpu_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_addr_ok;
   logic        i_data_ok;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_wr;
   logic [3:0]  d_sel;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_addr_ok;
   logic        d_data_ok;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_wr;
   logic [3:0]  m_sel;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_addr_ok;
   logic        m_data_ok;
   logic [31:0] m_rdata;
   logic        owner;

   int total = 0;
   int bad   = 0;

   cpu_mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_req(i_req),
      .i_addr(i_addr),
      .i_addr_ok(i_addr_ok),
      .i_data_ok(i_data_ok),
      .i_rdata(i_rdata),
      .d_req(d_req),
      .d_wr(d_wr),
      .d_sel(d_sel),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok),
      .d_data_ok(d_data_ok),
      .d_rdata(d_rdata),
      .m_req(m_req),
      .m_wr(m_wr),
      .m_sel(m_sel),
      .m_addr(m_addr),
      .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok),
      .m_data_ok(m_data_ok),
      .m_rdata(m_rdata),
      .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        ir;
      logic        dr;
      logic        mao;
      logic        mdo;
      logic        eia;
      logic        eda;
      logic        eid;
      logic        edd;
      logic        emr;
      logic        eown;
      logic [31:0] eaddr;
   } vec_t;

   localparam logic [31:0] IA = 32'hBFC0_0000;
   localparam logic [31:0] DA = 32'h8000_0004;

   vec_t vec [17];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   ng;
      int   pulses;
      logic exp_d;

      vec[0]  = {4'b1000, 6'b100000, 32'h0};
      vec[1]  = {4'b0010, 6'b000010, IA};
      vec[2]  = {4'b0001, 6'b001000, IA};
      vec[3]  = {4'b0000, 6'b000000, IA};
      vec[4]  = {4'b1100, 6'b010000, IA};
      vec[5]  = {4'b1010, 6'b000011, DA};
      vec[6]  = {4'b1001, 6'b000101, DA};
      vec[7]  = {4'b1000, 6'b100001, DA};
      vec[8]  = {4'b0010, 6'b000010, IA};
      vec[9]  = {4'b0001, 6'b001000, IA};
      vec[10] = {4'b0000, 6'b000000, IA};
      vec[11] = {4'b0001, 6'b000000, IA};
      vec[12] = {4'b0100, 6'b010000, IA};
      vec[13] = {4'b0001, 6'b000011, DA};
      vec[14] = {4'b0010, 6'b000011, DA};
      vec[15] = {4'b0001, 6'b000101, DA};
      vec[16] = {4'b0000, 6'b000001, DA};

      rst       = 1'b1;
      i_req     = 1'b0;
      i_addr    = IA;
      d_req     = 1'b0;
      d_wr      = 1'b0;
      d_sel     = 4'hF;
      d_addr    = DA;
      d_wdata   = 32'h0;
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      m_rdata   = 32'h0;

      #2;
      chk("rst_m", {m_req, m_wr, m_sel, m_addr, m_wdata}, 70'h0);
      chk("rst_ok", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 4'h0);
      chk("rst_owner", owner, 1'b0);
      next_cyc();
      next_cyc();
      rst = 1'b0;

      for (int k = 0; k < 17; k++) begin
         i_req     = vec[k].ir;
         d_req     = vec[k].dr;
         m_addr_ok = vec[k].mao;
         m_data_ok = vec[k].mdo;
         m_rdata   = 32'h2408_0001 + 32'(k);
         #3;
         chk($sformatf("v%0d_iaok", k), i_addr_ok, vec[k].eia);
         chk($sformatf("v%0d_daok", k), d_addr_ok, vec[k].eda);
         chk($sformatf("v%0d_idok", k), i_data_ok, vec[k].eid);
         chk($sformatf("v%0d_ddok", k), d_data_ok, vec[k].edd);
         chk($sformatf("v%0d_mreq", k), m_req, vec[k].emr);
         chk($sformatf("v%0d_own", k), owner, vec[k].eown);
         chk($sformatf("v%0d_addr", k), m_addr, vec[k].eaddr);
         if (vec[k].emr)
            chk($sformatf("v%0d_rdwr", k), {m_wr, m_sel}, 5'h0F);
         if (vec[k].eid)
            chk($sformatf("v%0d_irdata", k), i_rdata, 32'h2408_0001 + 32'(k));
         if (vec[k].edd)
            chk($sformatf("v%0d_drdata", k), d_rdata, 32'h2408_0001 + 32'(k));
         next_cyc();
      end

      // starvation: expect D D D D I D D D D I D
      ng = 0;
      for (int c = 0; c < 40; c++) begin
         i_req     = (ng < 11);
         d_req     = (ng < 11);
         m_addr_ok = 1'b1;
         m_data_ok = 1'b1;
         #3;
         if (i_addr_ok || d_addr_ok) begin
            exp_d = !(ng == 4 || ng == 9);
            chk($sformatf("starve_g%0d", ng), {i_addr_ok, d_addr_ok},
                {!exp_d, exp_d});
            ng++;
         end
         next_cyc();
      end
      chk("starve_count", ng, 11);

      // slow-ack D write
      i_req     = 1'b0;
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      d_req     = 1'b1;
      d_wr      = 1'b1;
      d_sel     = 4'b0011;
      d_wdata   = 32'hDEAD_BEEF;
      #3;
      chk("wr_grant", {i_addr_ok, d_addr_ok}, 2'b01);
      next_cyc();
      d_req   = 1'b0;
      d_wr    = 1'b0;
      d_sel   = 4'h0;
      d_wdata = 32'h0;
      for (int j = 0; j < 4; j++) begin
         m_addr_ok = (j == 3);
         #3;
         chk($sformatf("wr_hold%0d", j),
             {m_req, m_wr, m_sel, m_addr, m_wdata, owner},
             {1'b1, 1'b1, 4'b0011, DA, 32'hDEAD_BEEF, 1'b1});
         next_cyc();
      end
      pulses = 0;
      for (int j = 0; j < 4; j++) begin
         m_addr_ok = 1'b0;
         m_data_ok = (j == 1);
         #3;
         if (j == 0)
            chk("wr_data_mreq", m_req, 1'b0);
         if (d_data_ok)
            pulses++;
         next_cyc();
      end
      chk("wr_pulses", pulses, 1);

      // async reset during DATA with both requests held
      m_data_ok = 1'b0;
      i_req     = 1'b1;
      #3;
      chk("ar_grant", i_addr_ok, 1'b1);
      next_cyc();
      d_req     = 1'b1;
      m_addr_ok = 1'b1;
      next_cyc();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b1;
      #1;
      chk("ar_pre_idok", i_data_ok, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("ar_outs", {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok},
          5'h0);
      chk("ar_regs", {owner, m_addr, m_sel}, 37'h0);
      #1;
      rst = 1'b0;
      #1;
      chk("ar_regrant", {i_addr_ok, d_addr_ok, i_data_ok}, 3'b010);
      m_data_ok = 1'b0;
      next_cyc();
      i_req     = 1'b0;
      d_req     = 1'b0;
      m_addr_ok = 1'b1;
      #3;
      chk("ar_addr", {m_req, m_addr, owner}, {1'b1, DA, 1'b1});
      next_cyc();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b1;
      #3;
      chk("ar_ddok", {i_data_ok, d_data_ok}, 2'b01);
      next_cyc();
      m_data_ok = 1'b0;
      #3;
      chk("ar_idle", {m_req, d_data_ok, i_data_ok}, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
